// File: rtl/rab_pkg.sv
// ---------------------------------------------------------------------------
// rab_pkg
// Shared definitions for the RAB L2 TLB invalidation logic:
//   - tag word field offsets (valid bit, flag bits, VPN low bit)
//   - inv_state_t, the invalidation walker FSM encoding
//   - ram_word_addr(), tag RAM word address from set and entry
// ---------------------------------------------------------------------------
package rab_pkg;

    // Tag word layout: [0] valid, [3:1] flags, [VPN_LO +: VPN width] VPN
    localparam int unsigned TAG_VALID_BIT = 0;
    localparam int unsigned TAG_FLAG_LO   = 1;
    localparam int unsigned TAG_FLAG_HI   = 3;
    localparam int unsigned TAG_VPN_LO    = 4;

    typedef enum logic [2:0] {
        INV_IDLE  = 3'd0,
        INV_SETUP = 3'd1,
        INV_READ  = 3'd2,
        INV_CHECK = 3'd3,
        INV_WRITE = 3'd4,
        INV_DONE  = 3'd5
    } inv_state_t;

    // Word address of an entry: sets are laid out contiguously
    function automatic int unsigned ram_word_addr(input int unsigned set_idx,
                                                  input int unsigned entry_idx,
                                                  input int unsigned n_entries);
        return set_idx * n_entries + entry_idx;
    endfunction

endpackage

// File: rtl/rab_inv_range_cmp.sv
// ---------------------------------------------------------------------------
// rab_inv_range_cmp
// Combinational inclusive range check of a virtual page number. Shared by
// the L2 invalidation walker and the L1 slice invalidation.
// Ports:
//   vpn_i      page number under test
//   lo_i       first page of the range (inclusive)
//   hi_i       last page of the range (inclusive)
//   in_range_o 1 when lo_i <= vpn_i <= hi_i
// ---------------------------------------------------------------------------
module rab_inv_range_cmp #(
    parameter int unsigned VW = 20
) (
    input  logic [VW-1:0] vpn_i,
    input  logic [VW-1:0] lo_i,
    input  logic [VW-1:0] hi_i,
    output logic          in_range_o
);

    assign in_range_o = (vpn_i >= lo_i) && (vpn_i <= hi_i);

endmodule

// File: rtl/rab_l2_inv_walker.sv
// ---------------------------------------------------------------------------
// rab_l2_inv_walker
// Walks every L2 set an inclusive VA range can map to and clears the valid
// bit of each tag whose VPN lies inside the range.
// Ports:
//   Clk_CI, Rst_RI           clock, asynchronous active-high reset
//   Valid_SI / Ready_SO      request handshake (Ready_SO high only when idle)
//   Start_DI, End_DI         inclusive VA range
//   Busy_SO                  walk in progress (lookups stalled upstream)
//   Done_SO                  one-cycle completion pulse
//   RamGrant_SI              tag RAM granted this cycle
//   RamRdEn_SO, RamWrEn_SO   tag RAM read / write request
//   RamAddr_DO, RamWdata_DO  word address (set*N_SET_ENTRIES+entry), wdata
//   RamRdata_DI              read data, one cycle after a granted read
//   InvCnt_DO                invalidated-entry counter
// Build option: define RAB_INV_STATS_EN for the saturating InvCnt_DO
// counter; otherwise InvCnt_DO is tied to zero.
// ---------------------------------------------------------------------------
module rab_l2_inv_walker
    import rab_pkg::*;
#(
    parameter  int unsigned AW            = 32,
    parameter  int unsigned N_SETS        = 32,
    parameter  int unsigned N_SET_ENTRIES = 32,
    parameter  int unsigned PAGE_BITS     = 12,
    localparam int unsigned RAM_AW        = $clog2(N_SETS * N_SET_ENTRIES)
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Valid_SI,
    output logic              Ready_SO,
    input  logic [AW-1:0]     Start_DI,
    input  logic [AW-1:0]     End_DI,
    output logic              Busy_SO,
    output logic              Done_SO,
    input  logic              RamGrant_SI,
    output logic              RamRdEn_SO,
    output logic              RamWrEn_SO,
    output logic [RAM_AW-1:0] RamAddr_DO,
    output logic [AW-1:0]     RamWdata_DO,
    input  logic [AW-1:0]     RamRdata_DI,
    output logic [15:0]       InvCnt_DO
);

    localparam int unsigned VW = AW - PAGE_BITS;
    localparam int unsigned SW = $clog2(N_SETS);
    localparam int unsigned EW = $clog2(N_SET_ENTRIES);

    inv_state_t    state_q, state_d;
    logic [VW-1:0] svpn_q, svpn_d;
    logic [VW-1:0] evpn_q, evpn_d;
    logic [SW-1:0] set_q, set_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [AW:0]   sets_left_q, sets_left_d;
    logic [AW-1:0] wdata_q, wdata_d;

    logic [AW:0]   span_s;
    logic          empty_s;
    logic          in_range_s;
    logic          hit_s;
    logic          last_s;
    logic [SW-1:0] adv_set_s;
    logic [EW-1:0] adv_entry_s;
    logic [AW:0]   adv_sets_left_s;
    logic          unused_s;

    // Page offsets of the range bounds carry no information for the walk
    assign unused_s = ^{Start_DI[PAGE_BITS-1:0], End_DI[PAGE_BITS-1:0]};

    // Span is formed one bit wider so a full-address-space range cannot wrap
    assign span_s  = (AW+1)'(evpn_q) - (AW+1)'(svpn_q) + {{AW{1'b0}}, 1'b1};
    assign empty_s = (evpn_q < svpn_q);

    rab_inv_range_cmp #(
        .VW (VW)
    ) i_range_cmp (
        .vpn_i      (RamRdata_DI[TAG_VPN_LO +: VW]),
        .lo_i       (svpn_q),
        .hi_i       (evpn_q),
        .in_range_o (in_range_s)
    );

    assign hit_s  = RamRdata_DI[TAG_VALID_BIT] & in_range_s;
    assign last_s = (entry_q == EW'(N_SET_ENTRIES - 1)) &&
                    (sets_left_q == {{AW{1'b0}}, 1'b1});

    // Position after the current entry: entries first, then the next set
    always_comb begin
        adv_set_s       = set_q;
        adv_entry_s     = entry_q + {{(EW-1){1'b0}}, 1'b1};
        adv_sets_left_s = sets_left_q;
        if (entry_q == EW'(N_SET_ENTRIES - 1)) begin
            adv_entry_s     = '0;
            adv_set_s       = set_q + {{(SW-1){1'b0}}, 1'b1};
            adv_sets_left_s = sets_left_q - {{AW{1'b0}}, 1'b1};
        end else begin
            adv_set_s       = set_q;
        end
    end

    // Walker next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        svpn_d      = svpn_q;
        evpn_d      = evpn_q;
        set_d       = set_q;
        entry_d     = entry_q;
        sets_left_d = sets_left_q;
        wdata_d     = wdata_q;
        case (state_q)
            INV_IDLE: begin
                if (Valid_SI) begin
                    svpn_d  = Start_DI[AW-1:PAGE_BITS];
                    evpn_d  = End_DI[AW-1:PAGE_BITS];
                    state_d = INV_SETUP;
                end else begin
                    state_d = INV_IDLE;
                end
            end
            // One cycle to derive first set and set count from the latched VPNs
            INV_SETUP: begin
                set_d   = svpn_q[SW-1:0];
                entry_d = '0;
                if (empty_s) begin
                    sets_left_d = '0;
                    state_d     = INV_DONE;
                end else if (span_s > (AW+1)'(N_SETS)) begin
                    sets_left_d = (AW+1)'(N_SETS);
                    state_d     = INV_READ;
                end else begin
                    sets_left_d = span_s;
                    state_d     = INV_READ;
                end
            end
            INV_READ: begin
                if (RamGrant_SI) begin
                    state_d = INV_CHECK;
                end else begin
                    state_d = INV_READ;
                end
            end
            INV_CHECK: begin
                if (hit_s) begin
                    wdata_d                = RamRdata_DI;
                    wdata_d[TAG_VALID_BIT] = 1'b0;
                    state_d                = INV_WRITE;
                end else begin
                    set_d       = adv_set_s;
                    entry_d     = adv_entry_s;
                    sets_left_d = adv_sets_left_s;
                    state_d     = last_s ? INV_DONE : INV_READ;
                end
            end
            INV_WRITE: begin
                if (RamGrant_SI) begin
                    set_d       = adv_set_s;
                    entry_d     = adv_entry_s;
                    sets_left_d = adv_sets_left_s;
                    state_d     = last_s ? INV_DONE : INV_READ;
                end else begin
                    state_d = INV_WRITE;
                end
            end
            INV_DONE: begin
                state_d = INV_IDLE;
            end
            default: begin
                state_d = INV_IDLE;
            end
        endcase
    end

    // Walker state and datapath registers
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q     <= INV_IDLE;
            svpn_q      <= '0;
            evpn_q      <= '0;
            set_q       <= '0;
            entry_q     <= '0;
            sets_left_q <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            svpn_q      <= svpn_d;
            evpn_q      <= evpn_d;
            set_q       <= set_d;
            entry_q     <= entry_d;
            sets_left_q <= sets_left_d;
            wdata_q     <= wdata_d;
        end
    end

    assign Ready_SO    = (state_q == INV_IDLE);
    assign Busy_SO     = (state_q != INV_IDLE);
    assign Done_SO     = (state_q == INV_DONE);
    assign RamRdEn_SO  = (state_q == INV_READ);
    assign RamWrEn_SO  = (state_q == INV_WRITE);
    assign RamAddr_DO  = RAM_AW'(ram_word_addr(32'(set_q), 32'(entry_q), N_SET_ENTRIES));
    assign RamWdata_DO = wdata_q;

`ifdef RAB_INV_STATS_EN
    logic [15:0] inv_cnt_q;

    // Saturating count of granted invalidation writes
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            inv_cnt_q <= 16'h0000;
        end else if ((state_q == INV_WRITE) && RamGrant_SI && (inv_cnt_q != 16'hFFFF)) begin
            inv_cnt_q <= inv_cnt_q + 16'h0001;
        end else begin
            inv_cnt_q <= inv_cnt_q;
        end
    end

    assign InvCnt_DO = inv_cnt_q;
`else
    assign InvCnt_DO = 16'h0000;
`endif

endmodule
